adder_stim_check: RTL and testbench
===================================

# adder_stim_check

Clocked stimulus driver and result checker for the behavioural 4-bit carry-in adders. It accepts operand requests over a valid/ready handshake and drives the adder's `a`, `b` and `ci` inputs from registers. After a programmable settle window it samples `co` and `sum`, compares them with the arithmetic expectation and returns a pass/fail response with running counters. It sits between the testbench sequencer and the adder under test, and closes the loop on the adder's delayed outputs.

## Interface
- `WIDTH`, 4: operand width; result is `WIDTH+1` bits.
- `SETTLE`, 3: clock cycles from request acceptance to output sampling. Must be at least 1. Chosen to exceed the adder's propagation delay.
- `CNT_W`, 8: width of the transaction and error counters.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_a`, `req_b`  in  WIDTH  operands.
- `req_ci`  in  1  carry-in.
- `dut_a`, `dut_b`  out  WIDTH  registered drive to the adder.
- `dut_ci`  out  1  registered drive to the adder.
- `dut_co`  in  1  adder carry-out.
- `dut_sum`  in  WIDTH  adder sum.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_pass`  out  1  1 when `rsp_got == rsp_exp`.
- `rsp_got`  out  WIDTH+1  sampled `{dut_co, dut_sum}`.
- `rsp_exp`  out  WIDTH+1  expected `a + b + ci`.
- `clr_counts`  in  1  synchronous clear of both counters.
- `txn_count`  out  CNT_W  number of samples taken, saturating.
- `err_count`  out  CNT_W  number of mismatches, saturating.

## Operation
- **Reset.** While `rst` is high:
  - State is IDLE.
  - `dut_a`, `dut_b`, `dut_ci` are 0.
  - `rsp_valid`, `rsp_pass`, `rsp_got`, `rsp_exp`, `txn_count` and `err_count` are 0.
  - `req_ready` is 0.
- **IDLE.**
  - `req_ready` = 1.
  - On `req_valid & req_ready`: register the operands onto `dut_a`, `dut_b`, `dut_ci`; compute `rsp_exp` = zero-extended `req_a + req_b + req_ci` in WIDTH+1 bits (no truncation); clear the settle counter; go to WAIT.
- **WAIT.**
  - `req_ready` = 0.
  - The settle counter increments each edge.
  - On the edge where the counter equals SETTLE-1:
    - capture `{dut_co, dut_sum}` into `rsp_got`;
    - set `rsp_pass`;
    - increment `txn_count`, and `err_count` on a mismatch;
    - set `rsp_valid` = 1 and go to REPORT.
- **REPORT.**
  - `rsp_valid` = 1 with the `rsp_*` fields held stable.
  - On an edge with `rsp_ready` = 1: clear `rsp_valid` and go to IDLE.
  - `rsp_got`, `rsp_exp` and `rsp_pass` keep their last values after the response is taken.
- **Input hold.** `dut_a`, `dut_b` and `dut_ci` hold their values until the next accepted request. The adder never sees a change in WAIT or REPORT.
- **Counters.**
  - Both counters saturate at all-ones.
  - `clr_counts` zeroes both; clear wins over a simultaneous increment.
  - `clr_counts` does not affect the FSM.
- **Request changes.** `req_a`, `req_b` and `req_ci` changing outside an accept edge have no effect.
- **Reset mid-operation.** Reset in WAIT or REPORT aborts the transaction. No response and no count are produced. State returns to IDLE.

## Timing
- Accept at edge k. `dut_*` are valid after edge k.
- Sample at edge k+SETTLE. `rsp_valid` is high from edge k+SETTLE.
- With `rsp_ready` held at 1, the response transfers at edge k+SETTLE+1. The next accept can occur at edge k+SETTLE+2.
- Peak throughput is one transaction per SETTLE+2 cycles.
- `req_ready` is a decode of state with reset gating: it is high the first cycle after reset deassertion.
- `rsp_ready` held at 0 stalls in REPORT indefinitely with no loss. The adder inputs stay held throughout.

## Test plan
- **Single transaction.** With SETTLE=3, request a=4'h9, b=4'h5, ci=1 against the `adder_t11b`-style model at a 10-unit clock. Required: `rsp_valid` 3 cycles after accept; `rsp_exp`=5'h0F; `rsp_got`=5'h0F; `rsp_pass`=1; `txn_count`=1.
- **Overflow.** Request a=4'hF, b=4'hF, ci=1. Required: `rsp_exp`=5'h1F and `rsp_pass`=1.
- **Short settle window.** Use SETTLE=1 with the 12-unit adder at a 10-unit clock and a=3, b=4 after a previous 0+0. Required: `rsp_got`=0 (stale), `rsp_pass`=0, `err_count`=1.
- **Back-pressure.** Hold `rsp_ready`=0 for 5 cycles in REPORT. Required: `rsp_valid` stays 1, fields unchanged, `req_ready`=0. Transfer occurs on the first edge with `rsp_ready`=1.
- **Reset mid-WAIT.** Assert `rst` one cycle after accept. Required: all outputs 0, no response, `txn_count`=0, and `req_ready`=1 one cycle after release.
- **Saturation and clear.** With CNT_W=2, run 5 mismatching transactions. Required: `err_count`=3. Assert `clr_counts` on a sample edge. Required: both counters become 0 and that sample is not counted.

Source files
------------

// File: rtl/adder_stim_check.sv
// adder_stim_check: drives a WIDTH-bit carry-in adder from registers, samples its
// outputs after a programmable settle window and reports pass/fail with counters.
`timescale 1ns/1ps

module adder_stim_check #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_ci,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_ci,
  input  logic             dut_co,
  input  logic [WIDTH-1:0] dut_sum,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_pass,
  output logic [WIDTH:0]   rsp_got,
  output logic [WIDTH:0]   rsp_exp,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]    SLAST = SW'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CMAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [RW-1:0] got_c;
  logic          sample_c;
  logic          miss_c;

  // Adder result as seen this cycle, and the sample/mismatch decode shared by FSM and counters
  assign got_c    = {dut_co, dut_sum};
  assign sample_c = (state == S_WAIT) && (settle_cnt == SLAST);
  assign miss_c   = (got_c != rsp_exp);

  // Ready is a pure state decode, gated so it stays low while reset is held
  assign req_ready = (state == S_IDLE) && !rst;

  // Transaction FSM: accept, settle, sample, hold response until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      dut_a      <= '0;
      dut_b      <= '0;
      dut_ci     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_pass   <= 1'b0;
      rsp_got    <= '0;
      rsp_exp    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            dut_a      <= req_a;
            dut_b      <= req_b;
            dut_ci     <= req_ci;
            rsp_exp    <= RW'(req_a) + RW'(req_b) + RW'(req_ci);
            settle_cnt <= '0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          settle_cnt <= settle_cnt + SW'(1);
          if (settle_cnt == SLAST) begin
            rsp_got   <= got_c;
            rsp_pass  <= !miss_c;
            rsp_valid <= 1'b1;
            state     <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating sample/error counters; clear takes priority over a same-edge sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count <= '0;
      err_count <= '0;
    end else if (clr_counts) begin
      txn_count <= '0;
      err_count <= '0;
    end else if (sample_c) begin
      if (txn_count != CMAX) begin
        txn_count <= txn_count + CNT_W'(1);
      end
      if (miss_c && (err_count != CMAX)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_stim_check.sv
// Bench for adder_stim_check: two instances, one with a fast adder and a 3-cycle
// window, one with a slow adder, a 1-cycle window and 2-bit counters.
`timescale 1ns/1ps

module tb_adder_stim_check;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2];
  logic       req_valid[2];
  logic       req_ready[2];
  logic [3:0] req_a[2];
  logic [3:0] req_b[2];
  logic       req_ci[2];
  logic [3:0] dut_a[2];
  logic [3:0] dut_b[2];
  logic       dut_ci[2];
  logic       dut_co[2];
  logic [3:0] dut_sum[2];
  logic       rsp_valid[2];
  logic       rsp_ready[2];
  logic       rsp_pass[2];
  logic [4:0] rsp_got[2];
  logic [4:0] rsp_exp[2];
  logic       clr[2];
  logic [7:0] txn0, err0;
  logic [1:0] txn1, err1;
  logic [4:0] add_out0, add_out1;

  // Behavioural adders: instance 0 settles in 2 units, instance 1 needs 12
  always @(dut_a[0] or dut_b[0] or dut_ci[0])
    add_out0 <= #2 5'(dut_a[0]) + 5'(dut_b[0]) + 5'(dut_ci[0]);
  always @(dut_a[1] or dut_b[1] or dut_ci[1])
    add_out1 <= #12 5'(dut_a[1]) + 5'(dut_b[1]) + 5'(dut_ci[1]);

  assign dut_co[0]  = add_out0[4];
  assign dut_sum[0] = add_out0[3:0];
  assign dut_co[1]  = add_out1[4];
  assign dut_sum[1] = add_out1[3:0];

  adder_stim_check #(.WIDTH(4), .SETTLE(3), .CNT_W(8)) u_fast (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .req_ci(req_ci[0]),
    .dut_a(dut_a[0]), .dut_b(dut_b[0]), .dut_ci(dut_ci[0]),
    .dut_co(dut_co[0]), .dut_sum(dut_sum[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_pass(rsp_pass[0]),
    .rsp_got(rsp_got[0]), .rsp_exp(rsp_exp[0]),
    .clr_counts(clr[0]), .txn_count(txn0), .err_count(err0)
  );

  adder_stim_check #(.WIDTH(4), .SETTLE(1), .CNT_W(2)) u_slow (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .req_ci(req_ci[1]),
    .dut_a(dut_a[1]), .dut_b(dut_b[1]), .dut_ci(dut_ci[1]),
    .dut_co(dut_co[1]), .dut_sum(dut_sum[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_pass(rsp_pass[1]),
    .rsp_got(rsp_got[1]), .rsp_exp(rsp_exp[1]),
    .clr_counts(clr[1]), .txn_count(txn1), .err_count(err1)
  );

  // Reference model state
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned settle_m[2] = '{3, 1};
  int unsigned cmax_m[2]   = '{255, 3};
  int unsigned txn_m[2]    = '{0, 0};
  int unsigned err_m[2]    = '{0, 0};
  logic [4:0]  held_sum_m[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] txn_of(input int w);
    return (w == 0) ? 32'(txn0) : 32'(txn1);
  endfunction

  function automatic logic [31:0] err_of(input int w);
    return (w == 0) ? 32'(err0) : 32'(err1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int w);
    rst[w] = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready[w]), 0);
    chk("rst_dut_a", 32'(dut_a[w]), 0);
    chk("rst_dut_b", 32'(dut_b[w]), 0);
    chk("rst_dut_ci", 32'(dut_ci[w]), 0);
    chk("rst_rsp_valid", 32'(rsp_valid[w]), 0);
    chk("rst_rsp_pass", 32'(rsp_pass[w]), 0);
    chk("rst_rsp_got", 32'(rsp_got[w]), 0);
    chk("rst_rsp_exp", 32'(rsp_exp[w]), 0);
    chk("rst_txn", txn_of(w), 0);
    chk("rst_err", err_of(w), 0);
    rst[w] = 1'b0;
    #1;
    chk("rel_req_ready", 32'(req_ready[w]), 1);
    txn_m[w] = 0;
    err_m[w] = 0;
    held_sum_m[w] = 5'd0;
  endtask

  // One full request/response; the slow instance's model samples the previous sum
  task automatic txn(input int w, input logic [3:0] a, input logic [3:0] b, input logic ci,
                     input int stall, input bit clr_s);
    logic [4:0] exp_v;
    logic [4:0] got_v;
    int         lat;
    bit         seen;
    exp_v = 5'(a) + 5'(b) + 5'(ci);
    got_v = (w == 0) ? exp_v : held_sum_m[w];
    req_a[w] = a;
    req_b[w] = b;
    req_ci[w] = ci;
    req_valid[w] = 1'b1;
    chk("idle_ready", 32'(req_ready[w]), 1);
    tick();
    req_valid[w] = 1'b0;
    req_a[w] = 4'($urandom);
    req_b[w] = 4'($urandom);
    req_ci[w] = 1'($urandom);
    chk("drv_a", 32'(dut_a[w]), 32'(a));
    chk("drv_b", 32'(dut_b[w]), 32'(b));
    chk("drv_ci", 32'(dut_ci[w]), 32'(ci));
    chk("wait_ready", 32'(req_ready[w]), 0);
    held_sum_m[w] = exp_v;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      clr[w] = clr_s && (lat + 1 == int'(settle_m[w]));
      tick();
      lat++;
      clr[w] = 1'b0;
      seen = rsp_valid[w];
    end
    chk("latency", 32'(lat), 32'(settle_m[w]));
    if (!seen) return;
    if (clr_s) begin
      txn_m[w] = 0;
      err_m[w] = 0;
    end else begin
      if (txn_m[w] < cmax_m[w]) txn_m[w]++;
      if (got_v != exp_v && err_m[w] < cmax_m[w]) err_m[w]++;
    end
    chk("rsp_exp", 32'(rsp_exp[w]), 32'(exp_v));
    chk("rsp_got", 32'(rsp_got[w]), 32'(got_v));
    chk("rsp_pass", 32'(rsp_pass[w]), 32'(got_v == exp_v));
    chk("txn_count", txn_of(w), 32'(txn_m[w]));
    chk("err_count", err_of(w), 32'(err_m[w]));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", 32'(rsp_valid[w]), 1);
      chk("stall_ready", 32'(req_ready[w]), 0);
      chk("stall_got", 32'(rsp_got[w]), 32'(got_v));
      chk("stall_exp", 32'(rsp_exp[w]), 32'(exp_v));
      chk("stall_dut_a", 32'(dut_a[w]), 32'(a));
    end
    rsp_ready[w] = 1'b1;
    tick();
    rsp_ready[w] = 1'b0;
    chk("xfer_valid", 32'(rsp_valid[w]), 0);
    chk("xfer_ready", 32'(req_ready[w]), 1);
    chk("xfer_exp_held", 32'(rsp_exp[w]), 32'(exp_v));
    chk("xfer_dut_b", 32'(dut_b[w]), 32'(b));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] a, b;
    logic       ci;
    for (int w = 0; w < 2; w++) begin
      rst[w] = 1'b1;
      req_valid[w] = 1'b0;
      req_a[w] = 4'd0;
      req_b[w] = 4'd0;
      req_ci[w] = 1'b0;
      rsp_ready[w] = 1'b0;
      clr[w] = 1'b0;
      held_sum_m[w] = 5'd0;
    end
    do_reset(0);
    do_reset(1);

    // Fast adder, correct window: directed then random
    txn(0, 4'h9, 4'h5, 1'b1, 0, 1'b0);
    txn(0, 4'hF, 4'hF, 1'b1, 0, 1'b0);
    txn(0, 4'($urandom), 4'($urandom), 1'($urandom), 5, 1'b0);
    for (int i = 0; i < 8; i++)
      txn(0, 4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b0);

    // Reset one cycle into the settle window aborts the transaction
    req_a[0] = 4'h7;
    req_b[0] = 4'h6;
    req_ci[0] = 1'b0;
    req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    tick();
    rst[0] = 1'b1;
    #1;
    chk("mid_rst_dut_a", 32'(dut_a[0]), 0);
    chk("mid_rst_valid", 32'(rsp_valid[0]), 0);
    chk("mid_rst_exp", 32'(rsp_exp[0]), 0);
    chk("mid_rst_txn", txn_of(0), 0);
    chk("mid_rst_ready", 32'(req_ready[0]), 0);
    tick();
    rst[0] = 1'b0;
    #1;
    chk("mid_rel_ready", 32'(req_ready[0]), 1);
    txn_m[0] = 0;
    err_m[0] = 0;
    held_sum_m[0] = 5'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_rsp", 32'(rsp_valid[0]), 0);
    end
    chk("abort_txn", txn_of(0), 0);
    txn(0, 4'($urandom), 4'($urandom), 1'($urandom), 0, 1'b0);

    // Slow adder, 1-cycle window: stale samples, saturation and clear
    txn(1, 4'h0, 4'h0, 1'b0, 0, 1'b0);
    txn(1, 4'h3, 4'h4, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do begin
        a = 4'($urandom);
        b = 4'($urandom);
        ci = 1'($urandom);
      end while ((5'(a) + 5'(b) + 5'(ci)) == held_sum_m[1]);
      txn(1, a, b, ci, 0, 1'b0);
    end
    chk("sat_err", err_of(1), 3);
    do begin
      a = 4'($urandom);
      b = 4'($urandom);
      ci = 1'($urandom);
    end while ((5'(a) + 5'(b) + 5'(ci)) == held_sum_m[1]);
    txn(1, a, b, ci, 0, 1'b1);
    txn(1, 4'($urandom), 4'($urandom), 1'($urandom), 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
